// File: rtl/data_memory_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_memory_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/data_memory_port_mux.sv
// Owner select onto the memory address/write-enable/write-data inputs, and routing of
// the read return to the port whose read tag is set. Purely combinational.
module data_memory_port_mux
  import data_memory_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  arb_state_t        state,
  input  logic              req0,
  input  logic              req1,
  input  logic              write_en0,
  input  logic              write_en1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              rtag0,
  input  logic              rtag1,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    gnt0         = (state == OWN0) && req0;
    gnt1         = (state == OWN1) && req1;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    mem_wdata    = '0;
    // An owner whose request is low drives nothing, so the memory sees an idle cycle.
    if (gnt0) begin
      mem_addr     = addr0;
      mem_write_en = write_en0;
      mem_wdata    = data0;
    end else if (gnt1) begin
      mem_addr     = addr1;
      mem_write_en = write_en1;
      mem_wdata    = data1;
    end
  end

  assign rvalid0 = rtag0;
  assign rvalid1 = rtag1;
  assign rdata   = (rtag0 || rtag1) ? mem_rdata : '0;

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data_memory between port 0 (LSU) and port 1 (DMA); reads return one cycle after the beat.
// Define DATA_MEMORY_ARB_ROUND_ROBIN_EN for last-owner tie-break and MAX_BURST limiting; otherwise fixed priority to port 0.
module data_memory_arbiter
  import data_memory_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req0,
  input  logic              in_req1,
  input  logic              in_write_en0,
  input  logic              in_write_en1,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic              out_gnt0,
  output logic              out_gnt1,
  output logic              out_rvalid0,
  output logic              out_rvalid1,
  output logic [DATA_W-1:0] out_rdata,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_write_en,
  output logic [DATA_W-1:0] out_mem_data,
  input  logic [DATA_W-1:0] in_mem_data
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("data_memory_arbiter: MAX_BURST must be at least 1");
  end

  arb_state_t state, state_nxt;
  arb_state_t tie_state;
  logic       burst_end;
  logic       gnt0, gnt1;
  logic       rtag0, rtag1;

`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt;
  logic             last_owner;
  logic             beat;

  assign beat      = gnt0 | gnt1;
  assign burst_end = (cnt == CNT_LAST);
  assign tie_state = (last_owner == PORT0) ? OWN1 : OWN0;

  // Counter wraps while the other port is idle so the owner keeps streaming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      last_owner <= PORT1;
    end else begin
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= burst_end ? '0 : cnt + 1'b1;
      end
      if (state_nxt != state && state_nxt == OWN0) begin
        last_owner <= PORT0;
      end else if (state_nxt != state && state_nxt == OWN1) begin
        last_owner <= PORT1;
      end
    end
  end
`else
  assign burst_end = 1'b0;
  assign tie_state = OWN0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rtag0 <= 1'b0;
      rtag1 <= 1'b0;
    end else begin
      state <= state_nxt;
      rtag0 <= gnt0 & ~in_write_en0;
      rtag1 <= gnt1 & ~in_write_en1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_req0 && in_req1) state_nxt = tie_state;
        else if (in_req0)       state_nxt = OWN0;
        else if (in_req1)       state_nxt = OWN1;
      end
      OWN0: begin
        if (!in_req0)                  state_nxt = in_req1 ? OWN1 : IDLE;
        else if (burst_end && in_req1) state_nxt = OWN1;
      end
      OWN1: begin
        if (!in_req1)                  state_nxt = in_req0 ? OWN0 : IDLE;
        else if (burst_end && in_req0) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  data_memory_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .state        (state),
    .req0         (in_req0),
    .req1         (in_req1),
    .write_en0    (in_write_en0),
    .write_en1    (in_write_en1),
    .addr0        (in_addr0),
    .addr1        (in_addr1),
    .data0        (in_data0),
    .data1        (in_data1),
    .rtag0        (rtag0),
    .rtag1        (rtag1),
    .mem_rdata    (in_mem_data),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .mem_addr     (out_mem_addr),
    .mem_write_en (out_mem_write_en),
    .mem_wdata    (out_mem_data),
    .rvalid0      (out_rvalid0),
    .rvalid1      (out_rvalid1),
    .rdata        (out_rdata)
  );

  assign out_gnt0 = gnt0;
  assign out_gnt1 = gnt1;

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter sharing the single-port `data_memory` (10-bit address, 8-bit data) between requester 0 (CPU load/store unit) and requester 1 (DMA/loader port). It owns the memory's address, write-enable and write-data inputs. Bursts are bounded so neither requester is starved. Read data is routed back with a one-cycle valid tag. It sits between the core/DMA and the `data_memory` instance.

## Interface
- `ADDR_W`, 10, memory address width
- `DATA_W`, 8, memory data width
- `MAX_BURST`, 4, max consecutive beats per ownership when the other port waits (≥1)
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_req0` / `in_req1`  in  1  access request, held until granted
- `in_write_en0` / `in_write_en1`  in  1  1 = write, 0 = read
- `in_addr0` / `in_addr1`  in  ADDR_W  access address
- `in_data0` / `in_data1`  in  DATA_W  write data
- `out_gnt0` / `out_gnt1`  out  1  beat accepted at the next rising edge
- `out_rvalid0` / `out_rvalid1`  out  1  `out_rdata` holds that port's read result
- `out_rdata`  out  DATA_W  read data, shared by both ports
- `out_mem_addr`  out  ADDR_W  to `data_memory.in_addr`
- `out_mem_write_en`  out  1  to `data_memory.in_write_en`
- `out_mem_data`  out  DATA_W  to `data_memory.in_data`
- `in_mem_data`  in  DATA_W  from `data_memory.out_data`

## Operation
- FSM states: IDLE, OWN0, OWN1. Registered state, beat counter, `last_owner`, and read tag.
- Grants: `out_gnt0 = (state==OWN0) & in_req0`; `out_gnt1` likewise. A beat transfers on the edge where `gnt` is high.
- Memory outputs are combinational from the owner's inputs:
  - `out_mem_write_en = gnt & owner write_en`.
  - With no owner, or owner `req` low: addr = 0, data = 0, write_en = 0.
- Transitions out of IDLE:
  - Only one port requesting: go to that port's OWN state.
  - Both requesting: go to OWN of port ≠ `last_owner`.
- Transitions out of OWNx:
  - `in_reqx` low and other port requesting: go to OWNother.
  - `in_reqx` low and other port idle: go to IDLE.
  - Beat accepted, counter = MAX_BURST-1, and other port requesting: go to OWNother.
  - Otherwise stay in OWNx.
- Beat counter: increments per accepted beat. Clears on any state change. If it reaches MAX_BURST-1 while the other port is idle, it wraps to 0 and ownership is kept.
- `last_owner` updates on every entry to an OWN state.
- Read return: a read beat at edge k sets `out_rvalidx` high for exactly the cycle after edge k. `out_rdata = in_mem_data`. Write beats give no rvalid.
- `out_rdata` is 0 when no rvalid is high.
- Simultaneous requests at reset release: port 0 wins, because `last_owner` resets to 1.

## Timing
- Reset values: state IDLE, counter 0, `last_owner` 1, all `gnt`/`rvalid` 0, `out_mem_write_en` 0, `out_mem_addr` 0, `out_mem_data` 0, `out_rdata` 0.
- Reset mid-burst aborts immediately. No write is issued while reset is asserted.
- Request latency from IDLE: `req` seen at edge k → `gnt` high in cycle k+1 → beat at edge k+1.
- Back-to-back beats: 1 per cycle while owned.
- Ownership handover: the last owner beat at edge k; the new owner's `gnt` is high in cycle k+1, with no bubble.
- Owner dropping `req` while the other port waits: exactly one idle memory cycle.
- Read data valid 1 cycle after the read beat edge. A write then a read to the same address on consecutive beats returns the new data.

## Configuration
- `DATA_MEMORY_ARB_ROUND_ROBIN_EN` defined:
  - Tie-break in IDLE uses `last_owner`.
  - The MAX_BURST limit is enforced.
- Not defined:
  - Fixed priority: a tie in IDLE always goes to port 0.
  - MAX_BURST is ignored; the owner keeps the grant until it drops `req`.
  - The counter and `last_owner` are not synthesized.

## Structure
- Package `data_memory_arb_pkg`: state enum (IDLE/OWN0/OWN1), port index constants `PORT0`/`PORT1`, default widths.
- One sub-module, `data_memory_port_mux`: combinational owner-select for addr/write_en/data plus read-tag demux. The FSM and counter stay in the top.

## Test plan
- Reset release with only `in_req0`, write 0x55 to addr 0 → `gnt0` in cycle 1, `out_mem_write_en`=1, `out_mem_addr`=0. A later port-0 read of addr 0 gives `out_rvalid0`=1 and `out_rdata`=0x55 one cycle after the beat.
- Both ports request at reset release → port 0 granted first. With RR, port 1 is granted after 4 port-0 beats with no bubble.
- Port 1 writes 0x02/0x04/0x08 to addr 1/2/3, then reads them back → `out_rvalid1` pulses with 0x02, 0x04, 0x08 in order. `out_rvalid0` stays 0.
- Port 0 holds `req` for 10 beats while port 1 is idle → `gnt0` continuous for 10 cycles and the counter wraps. Without the macro, port 1 requesting at beat 3 waits until port 0 drops `req`.
- Reset asserted mid-burst with a write pending → `out_mem_write_en` drops to 0 asynchronously and `gnt`/`rvalid` go to 0. After release, the FSM restarts from IDLE.
- Owner drops `req` while the other port is requesting → one cycle with `out_mem_write_en`=0 and both grants low, then the other port is granted.
